i2s_receiver: RTL and testbench
===============================

I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have port in_clk, input, 1: system clock; must be at least 4x bck frequency.
REQ-002 SHALL have port in_reset_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port audio_start, input, 1: one-cycle pulse; enables reception.
REQ-004 SHALL have port audio_end, input, 1: one-cycle pulse; disables reception.
REQ-005 SHALL have port mode_22khz, input, 1: 1 = emit every second frame.
REQ-006 SHALL have port bck, input, 1: I2S bit clock; asynchronous to in_clk.
REQ-007 SHALL have port lrck, input, 1: word select; 0 = left, 1 = right; asynchronous.
REQ-008 SHALL have port sdin, input, 1: serial data, MSB first; asynchronous.
REQ-009 SHALL have port out_valid, output, 1: out_data holds an unconsumed frame.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the frame when out_valid && out_ready.
REQ-011 SHALL have port out_data, output, 32: {left[15:0], right[15:0]}.
REQ-012 SHALL have port active, output, 1: high while in state ACQUIRE or RUN.
REQ-013 SHALL have port overrun, output, 1: one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port frame_err, output, 1: one-cycle pulse on framing error.

Function
REQ-015 SHALL pass bck, lrck and sdin through 2-flop synchronizers and act only on the synchronized bck rising edge ("tick"); lrck and sdin are sampled at the tick.
REQ-016 SHALL implement states DISABLED, ACQUIRE and RUN.
  - DISABLED -> ACQUIRE on audio_start.
  - ACQUIRE -> RUN on the first tick where sampled lrck falls 1->0.
  - Any state -> DISABLED on audio_end; audio_end wins over a simultaneous audio_start.
  - audio_start in ACQUIRE or RUN has no effect.
REQ-017 SHALL index ticks n = 0 at the tick where sampled lrck differs from its previous sample; n increments on each later tick.
REQ-018 SHALL shift sdin at n = 1..16 into the current channel, MSB first; sdin at n = 0 and n = 17..31 is ignored.
REQ-019 SHALL treat an lrck change at n != 32, or no change by n = 32, as a framing error in RUN: pulse frame_err, discard the partial frame, go to ACQUIRE.
REQ-020 SHALL complete a frame at the right-channel tick n = 16, and assert out_valid within 4 in_clk cycles of the bck pin rising edge that caused that tick.
REQ-021 SHALL hold out_valid and out_data stable until accepted; out_valid deasserts the cycle after acceptance.
REQ-022 SHALL handle a frame completing while out_valid && !out_ready as follows: drop the new frame, keep the old one, pulse overrun.
REQ-023 SHALL, when a frame completes in the same cycle as acceptance, load the new frame with out_valid remaining high and no overrun.
REQ-024 SHALL, on audio_end, drop any pending frame; out_valid is low from the next cycle.

Reset
REQ-025 SHALL on in_reset_n low, regardless of clock, set the state to DISABLED, synchronizers and counters to 0, and out_valid, out_data, active, overrun and frame_err to 0.
REQ-026 SHALL, after in_reset_n rises mid-stream, emit nothing until audio_start followed by an lrck falling edge.

Configuration
REQ-027 SHALL compile 22 kHz decimation only when I2S_RX_DEC22_EN is defined.
  - Defined, mode_22khz = 1: emit the first frame after entering RUN, then every second frame; skipped frames never cause overrun.
  - Not defined: mode_22khz is ignored and every frame is emitted.

Structure
REQ-028 SHALL place the following in shared package i2s_pkg: BCK_PER_CH = 32, SAMPLE_BITS = 16, FRAME_BITS = 32, and the state enum.
REQ-029 SHALL implement synchronization and edge detection in sub-module i2s_sync, instantiated once per input (bck, lrck, sdin).

Verification
REQ-030 SHALL cover normal reception: audio_start, then 64-bck frames of left = 16'hD999, right = 16'h9991, with out_ready = 1 -> out_data = 32'hD9999991, one out_valid pulse per frame.
REQ-031 SHALL cover backpressure: out_ready = 0 for 3 frames -> first frame held, 2 overrun pulses; out_ready = 1 -> first frame accepted.
REQ-032 SHALL cover framing: lrck toggles at n = 20 -> frame_err pulse, state ACQUIRE, next valid frame received correctly after an lrck fall.
REQ-033 SHALL cover decimation: I2S_RX_DEC22_EN defined, mode_22khz = 1, 6 frames sent -> frames 1, 3 and 5 emitted, no overrun.
REQ-034 SHALL cover control events:
  - audio_end with out_valid = 1 -> out_valid = 0 next cycle, active = 0.
  - Simultaneous audio_start and audio_end -> state stays DISABLED.
REQ-035 SHALL cover reset: in_reset_n pulsed low mid-frame -> all outputs 0 immediately; no frame emitted until re-enabled.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and FSM state encoding for the I2S receiver.
`timescale 1ns/1ps
package i2s_pkg;

  localparam int unsigned BCK_PER_CH  = 32;
  localparam int unsigned SAMPLE_BITS = 16;
  localparam int unsigned FRAME_BITS  = 32;
  localparam int unsigned CNT_W       = 6;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ACQUIRE  = 2'd1,
    RUN      = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for one asynchronous pin, with edge detection on the synchronized level.
`timescale 1ns/1ps
module i2s_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise_c = q & ~prev;
  assign fall_c = ~q & prev;

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: 16-bit stereo frames from 64-bck I2S slots, ready/valid output.
// Optional 22 kHz decimation (emit every second frame) is compiled in with I2S_RX_DEC22_EN.
`timescale 1ns/1ps
module i2s_receiver
  import i2s_pkg::*;
(
  input  logic        in_clk,
  input  logic        in_reset_n,
  input  logic        audio_start,
  input  logic        audio_end,
  input  logic        mode_22khz,
  input  logic        bck,
  input  logic        lrck,
  input  logic        sdin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        active,
  output logic        overrun,
  output logic        frame_err
);

  state_t state, state_nxt;

  logic tick, lrck_s, sdin_s;
  logic bck_fall_unused, lrck_rise_unused, lrck_fall_unused, sdin_rise_unused, sdin_fall_unused;

  logic                   lrck_prev;
  logic [CNT_W-1:0]       n;
  logic [SAMPLE_BITS-1:0] left_sr;
  logic [SAMPLE_BITS-2:0] right_sr;

  logic changed_c, lrck_fall_c, err_c, done_c, shift_c, emit_c;
  logic active_nxt, overrun_nxt, frame_err_nxt, load_c;
  logic [FRAME_BITS-1:0] frame_c;

  i2s_sync u_sync_bck  (.clk(in_clk), .rst_n(in_reset_n), .d(bck),  .q(),
                        .rise_c(tick), .fall_c(bck_fall_unused));
  i2s_sync u_sync_lrck (.clk(in_clk), .rst_n(in_reset_n), .d(lrck), .q(lrck_s),
                        .rise_c(lrck_rise_unused), .fall_c(lrck_fall_unused));
  i2s_sync u_sync_sdin (.clk(in_clk), .rst_n(in_reset_n), .d(sdin), .q(sdin_s),
                        .rise_c(sdin_rise_unused), .fall_c(sdin_fall_unused));

  // Slot decode: n is the tick index since the last lrck change.
  assign changed_c   = lrck_s ^ lrck_prev;
  assign lrck_fall_c = tick & lrck_prev & ~lrck_s;
  assign err_c       = tick && (state == RUN) &&
                       (changed_c ? (n != CNT_W'(BCK_PER_CH - 1)) : (n == CNT_W'(BCK_PER_CH - 1)));
  assign done_c      = tick && (state == RUN) && !changed_c && lrck_s &&
                       (n == CNT_W'(SAMPLE_BITS - 1));
  assign shift_c     = tick && !changed_c && (n < CNT_W'(SAMPLE_BITS));
  assign frame_c     = {left_sr, right_sr, sdin_s};

`ifdef I2S_RX_DEC22_EN
  logic skip;

  assign emit_c = !mode_22khz || !skip;

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      skip <= 1'b0;
    end else if (state != RUN && state_nxt == RUN) begin
      skip <= 1'b0;
    end else if (done_c && !audio_end) begin
      skip <= mode_22khz & ~skip;
    end
  end
`else
  logic mode_unused;

  assign mode_unused = mode_22khz;
  assign emit_c      = 1'b1;
`endif

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) state <= DISABLED;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (audio_end) begin
      state_nxt = DISABLED;
    end else begin
      case (state)
        DISABLED: if (audio_start) state_nxt = ACQUIRE;
        ACQUIRE:  if (lrck_fall_c) state_nxt = RUN;
        RUN:      if (err_c)       state_nxt = ACQUIRE;
        default:  state_nxt = DISABLED;
      endcase
    end
  end

  always_comb begin
    active_nxt    = (state_nxt != DISABLED);
    overrun_nxt   = 1'b0;
    frame_err_nxt = 1'b0;
    load_c        = 1'b0;
    if (!audio_end) begin
      frame_err_nxt = err_c;
      if (done_c && emit_c) begin
        if (out_valid && !out_ready) overrun_nxt = 1'b1;
        else                         load_c      = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      lrck_prev <= 1'b0;
      n         <= '0;
      left_sr   <= '0;
      right_sr  <= '0;
    end else if (tick) begin
      lrck_prev <= lrck_s;
      n         <= changed_c ? '0 : n + CNT_W'(1);
      if (shift_c && !lrck_s) left_sr  <= {left_sr[SAMPLE_BITS-2:0], sdin_s};
      if (shift_c &&  lrck_s) right_sr <= {right_sr[SAMPLE_BITS-3:0], sdin_s};
    end
  end

  // Output holding register: new frames only replace an empty or just-accepted slot.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      active    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      active    <= active_nxt;
      overrun   <= overrun_nxt;
      frame_err <= frame_err_nxt;
      if (audio_end) begin
        out_valid <= 1'b0;
      end else if (load_c) begin
        out_valid <= 1'b1;
        out_data  <= frame_c;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed self-checking bench for i2s_receiver; decimation expectations follow I2S_RX_DEC22_EN.
`timescale 1ns/1ps
module tb_i2s_receiver;
  import i2s_pkg::*;

  logic        in_clk = 1'b0;
  logic        in_reset_n = 1'b0;
  logic        audio_start = 1'b0;
  logic        audio_end = 1'b0;
  logic        mode_22khz = 1'b0;
  logic        bck = 1'b0;
  logic        lrck = 1'b0;
  logic        sdin = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        active;
  logic        overrun;
  logic        frame_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rx_q[$];
  int          ov_cnt = 0;
  int          fe_cnt = 0;
  int          vhi_cnt = 0;
  time         t_done = 0;
  time         last_lat = 0;
  logic        valid_d = 1'b0;

  i2s_receiver dut (
    .in_clk(in_clk), .in_reset_n(in_reset_n), .audio_start(audio_start),
    .audio_end(audio_end), .mode_22khz(mode_22khz), .bck(bck), .lrck(lrck),
    .sdin(sdin), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .active(active), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 in_clk = ~in_clk;

  // Observe handshakes and pulses 1 ns before each rising edge.
  always @(negedge in_clk) begin
    #4;
    if (out_valid && out_ready) rx_q.push_back(out_data);
    if (overrun)   ov_cnt++;
    if (frame_err) fe_cnt++;
    if (out_valid) vhi_cnt++;
    if (out_valid && !valid_d) last_lat = $time - t_done;
    valid_d = out_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge in_clk);
  endtask

  task automatic clear_stats();
    rx_q.delete();
    ov_cnt = 0;
    fe_cnt = 0;
    vhi_cnt = 0;
  endtask

  task automatic slot(input logic lr, input logic d);
    lrck = lr;
    sdin = d;
    #40 bck = 1'b1;
    #40 bck = 1'b0;
  endtask

  task automatic preamble();
    for (int k = 0; k < 4; k++) slot(1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    logic [15:0] s;
    for (int ch = 0; ch < 2; ch++) begin
      s = (ch == 0) ? l : r;
      for (int k = 0; k < 32; k++) begin
        if (ch == 1 && k == 16) t_done = $time + 40;
        slot(ch == 1, (k >= 1 && k <= 16) ? s[16-k] : 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge in_clk);
    in_reset_n = 1'b0;
    audio_start = 1'b0; audio_end = 1'b0; mode_22khz = 1'b0;
    bck = 1'b0; lrck = 1'b0; sdin = 1'b0; out_ready = 1'b0;
    @(negedge in_clk);
    in_reset_n = 1'b1;
    @(negedge in_clk);
  endtask

  task automatic pulse_start();
    audio_start = 1'b1;
    @(negedge in_clk);
    audio_start = 1'b0;
  endtask

  task automatic fresh_start();
    do_reset();
    pulse_start();
    clear_stats();
  endtask

  task automatic test_reset();
    in_reset_n = 1'b0;
    #22;
    checks++;
    if ({out_valid, active, overrun, frame_err} !== 4'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b a=%b o=%b f=%b d=%h exp all 0",
               out_valid, active, overrun, frame_err, out_data);
    end
    @(negedge in_clk);
    in_reset_n = 1'b1;
    wait_cycles(2);
    checks++;
    if (active !== 1'b0 || dut.state !== DISABLED) begin
      errors++;
      $display("FAIL reset_state got active=%b state=%0d exp 0/DISABLED", active, dut.state);
    end
  endtask

  task automatic test_normal();
    logic [31:0] exp_q[3];
    exp_q[0] = 32'hD9999991; exp_q[1] = 32'h1234ABCD; exp_q[2] = 32'h80017FFE;
    fresh_start();
    out_ready = 1'b1;
    checks++;
    if (active !== 1'b1) begin errors++; $display("FAIL normal_active got %b exp 1", active); end
    preamble();
    send_frame(16'hD999, 16'h9991);
    send_frame(16'h1234, 16'hABCD);
    send_frame(16'h8001, 16'h7FFE);
    wait_cycles(8);
    checks++;
    if (rx_q.size() != 3) begin errors++; $display("FAIL normal_count got %0d exp 3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_q.size() > i && rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL normal_data%0d got %h exp %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (vhi_cnt != 3) begin errors++; $display("FAIL normal_valid_cycles got %0d exp 3", vhi_cnt); end
    checks++;
    if (ov_cnt != 0 || fe_cnt != 0) begin
      errors++; $display("FAIL normal_pulses got ov=%0d fe=%0d exp 0/0", ov_cnt, fe_cnt);
    end
    checks++;
    if (last_lat > 40 || last_lat == 0) begin
      errors++; $display("FAIL normal_latency got %0t exp <=40ns", last_lat);
    end
  endtask

  task automatic test_backpressure();
    fresh_start();
    preamble();
    send_frame(16'hD999, 16'h9991);
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    wait_cycles(6);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hD9999991) begin
      errors++; $display("FAIL bp_hold got v=%b d=%h exp 1/d9999991", out_valid, out_data);
    end
    checks++;
    if (ov_cnt != 2) begin errors++; $display("FAIL bp_overrun got %0d exp 2", ov_cnt); end
    out_ready = 1'b1;
    wait_cycles(2);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'hD9999991) begin
      errors++; $display("FAIL bp_accept got n=%0d exp 1 frame d9999991", rx_q.size());
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", out_valid); end
  endtask

  task automatic test_framing();
    fresh_start();
    out_ready = 1'b1;
    preamble();
    send_frame(16'hD999, 16'h9991);
    for (int k = 0; k < 20; k++) slot(1'b0, 1'b1);
    for (int k = 0; k < 32; k++) slot(1'b1, 1'b0);
    checks++;
    if (fe_cnt != 1) begin errors++; $display("FAIL frame_err_pulse got %0d exp 1", fe_cnt); end
    checks++;
    if (dut.state !== ACQUIRE || active !== 1'b1) begin
      errors++; $display("FAIL frame_state got state=%0d active=%b exp ACQUIRE/1", dut.state, active);
    end
    send_frame(16'h1234, 16'hABCD);
    wait_cycles(6);
    checks++;
    if (rx_q.size() != 2 || rx_q[1] !== 32'h1234ABCD) begin
      errors++; $display("FAIL frame_recover got n=%0d exp 2 frames ending 1234abcd", rx_q.size());
    end
  endtask

  task automatic test_decimation();
    logic [31:0] exp_q[$];
    fresh_start();
    out_ready = 1'b1;
    mode_22khz = 1'b1;
    preamble();
    for (int k = 1; k <= 6; k++) begin
      send_frame(16'h1000 + 16'(k), 16'h2000 + 16'(k));
`ifdef I2S_RX_DEC22_EN
      if (k % 2 == 1) exp_q.push_back({16'h1000 + 16'(k), 16'h2000 + 16'(k)});
`else
      exp_q.push_back({16'h1000 + 16'(k), 16'h2000 + 16'(k)});
`endif
    end
    wait_cycles(6);
    mode_22khz = 1'b0;
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL dec_count got %0d exp %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL dec_data%0d got %h exp %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ov_cnt != 0) begin errors++; $display("FAIL dec_overrun got %0d exp 0", ov_cnt); end
  endtask

  task automatic test_control();
    fresh_start();
    preamble();
    send_frame(16'hD999, 16'h9991);
    wait_cycles(6);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ctl_pending got %b exp 1", out_valid); end
    audio_end = 1'b1;
    @(negedge in_clk);
    audio_end = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || active !== 1'b0) begin
      errors++; $display("FAIL ctl_end got v=%b a=%b exp 0/0", out_valid, active);
    end
    audio_start = 1'b1;
    audio_end = 1'b1;
    @(negedge in_clk);
    audio_start = 1'b0;
    audio_end = 1'b0;
    @(negedge in_clk);
    checks++;
    if (active !== 1'b0 || dut.state !== DISABLED) begin
      errors++; $display("FAIL ctl_both got active=%b state=%0d exp 0/DISABLED", active, dut.state);
    end
    clear_stats();
    out_ready = 1'b1;
    preamble();
    send_frame(16'h5555, 16'hAAAA);
    wait_cycles(6);
    checks++;
    if (vhi_cnt != 0) begin errors++; $display("FAIL ctl_disabled_rx got %0d exp 0", vhi_cnt); end
  endtask

  task automatic test_reset_midstream();
    fresh_start();
    preamble();
    send_frame(16'hD999, 16'h9991);
    for (int k = 0; k < 10; k++) slot(1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got %b exp 1", out_valid); end
    #3 in_reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, active, overrun, frame_err} !== 4'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL rst_async got v=%b a=%b o=%b f=%b d=%h exp all 0",
                         out_valid, active, overrun, frame_err, out_data);
    end
    @(negedge in_clk);
    in_reset_n = 1'b1;
    clear_stats();
    out_ready = 1'b1;
    for (int k = 10; k < 32; k++) slot(1'b0, 1'b0);
    for (int k = 0; k < 32; k++) slot(1'b1, 1'b0);
    send_frame(16'h1234, 16'hABCD);
    wait_cycles(6);
    checks++;
    if (vhi_cnt != 0 || active !== 1'b0) begin
      errors++; $display("FAIL rst_silent got valid_cycles=%0d active=%b exp 0/0", vhi_cnt, active);
    end
    pulse_start();
    preamble();
    send_frame(16'h8001, 16'h7FFE);
    wait_cycles(6);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 32'h80017FFE) begin
      errors++; $display("FAIL rst_resume got n=%0d exp 1 frame 80017ffe", rx_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_framing();
    test_decimation();
    test_control();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
